// File: rtl/dm_arbiter_if.sv
// Request, grant and memory-side signals of the data-memory arbiter.
// Latency: none, wiring only.  Backpressure: req is held until gnt.
// DM_ARB_LOCK_EN adds spi_lock, which keeps the host off the memory.
interface dm_arbiter_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
);
`ifdef DM_ARB_LOCK_EN
  logic                  spi_lock;
`endif
  logic                  spi_req;
  logic                  spi_we;
  logic [ADDR_WIDTH-1:0] spi_addr;
  logic [DATA_WIDTH-1:0] spi_wdata;
  logic                  spi_gnt;
  logic                  spi_rvalid;
  logic                  host_req;
  logic                  host_we;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0] host_wdata;
  logic                  host_gnt;
  logic                  host_rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic                  dm_we;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic [DATA_WIDTH-1:0] dm_rdata;

  modport slave (
`ifdef DM_ARB_LOCK_EN
    input  spi_lock,
`endif
    input  spi_req, spi_we, spi_addr, spi_wdata,
    output spi_gnt, spi_rvalid,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rvalid,
    output rdata,
    output dm_addr, dm_we, dm_wdata,
    input  dm_rdata
  );

  modport master (
`ifdef DM_ARB_LOCK_EN
    output spi_lock,
`endif
    output spi_req, spi_we, spi_addr, spi_wdata,
    input  spi_gnt, spi_rvalid,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rvalid,
    input  rdata,
    input  dm_addr, dm_we, dm_wdata,
    output dm_rdata
  );
endinterface

// File: rtl/dm_arbiter.sv
// Shares one single-port data memory between the SPI datapath and a local host.
// Latency: req sampled at edge N, gnt in cycle N+1, rvalid/rdata in cycle N+2.
// Backpressure: SPI has fixed priority with a host starvation guard; DM_ARB_LOCK_EN adds spi_lock.
module dm_arbiter #(
  parameter int ADDR_WIDTH   = 7,
  parameter int DATA_WIDTH   = 8,
  parameter int STARVE_LIMIT = 4
) (
  input logic        clk,
  input logic        rst_n,
  dm_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic { IDLE, GRANT } state_t;
  typedef enum logic { SEL_SPI, SEL_HOST } sel_t;

  state_t                state;
  sel_t                  sel;
  logic [CW-1:0]         starve_cnt;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  spi_rvalid_q;
  logic                  host_rvalid_q;

  logic                  lock;
  logic                  host_win;
  logic                  spi_win;
  logic                  host_sel;
  logic                  cur_we;
  logic [ADDR_WIDTH-1:0] addr_mux;
  logic [DATA_WIDTH-1:0] wdata_mux;

`ifdef DM_ARB_LOCK_EN
  assign lock = bus.spi_lock;
`else
  assign lock = 1'b0;
`endif

  assign host_win  = bus.host_req && !lock && (!bus.spi_req || starve_cnt == LIMIT);
  assign spi_win   = bus.spi_req && !host_win;
  assign host_sel  = (sel == SEL_HOST);
  assign cur_we    = host_sel ? bus.host_we : bus.spi_we;
  assign addr_mux  = host_sel ? bus.host_addr : bus.spi_addr;
  assign wdata_mux = host_sel ? bus.host_wdata : bus.spi_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sel           <= SEL_SPI;
      starve_cnt    <= '0;
      rdata_q       <= '0;
      spi_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
    end else begin
      spi_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (host_win || spi_win) begin
            sel   <= host_win ? SEL_HOST : SEL_SPI;
            state <= GRANT;
          end
          // A lost host decision ages the host; a lock, a host win or no host request resets it.
          if (bus.host_req && spi_win && !lock)
            starve_cnt <= (starve_cnt == LIMIT) ? LIMIT : starve_cnt + 1'b1;
          else
            starve_cnt <= '0;
        end
        GRANT: begin
          if (!cur_we) begin
            rdata_q <= bus.dm_rdata;
            if (host_sel) host_rvalid_q <= 1'b1;
            else          spi_rvalid_q  <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset forces IDLE asynchronously, so a write in flight loses dm_we before the edge.
  assign bus.spi_gnt     = (state == GRANT) && !host_sel;
  assign bus.host_gnt    = (state == GRANT) && host_sel;
  assign bus.dm_we       = (state == GRANT) && cur_we;
  assign bus.dm_addr     = addr_mux;
  assign bus.dm_wdata    = wdata_mux;
  assign bus.rdata       = rdata_q;
  assign bus.spi_rvalid  = spi_rvalid_q;
  assign bus.host_rvalid = host_rvalid_q;
endmodule

// File: tb/tb_dm_arbiter.sv
// Randomized scoreboard bench for dm_arbiter against a transaction-level arbitration model.
module tb_dm_arbiter;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int SL = 4;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } op_t;

  typedef struct packed {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [31:0]   cyc;
  } gnt_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [31:0]   cyc;
  } rd_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_init = 1'b1;
  logic        sb_en = 1'b0;
  logic [31:0] cyc = '0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dm_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dm_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [DW-1:0] seed_val(input int i);
    return (i == 5) ? 8'h11 : 8'(i * 37 + 11);
  endfunction

  // Memory seen by the DUT: combinational read, write on the edge.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= seed_val(i);
    end else if (bus.dm_we) begin
      mem[bus.dm_addr] <= bus.dm_wdata;
    end
  end
  assign bus.dm_rdata = mem[bus.dm_addr];

  // Reference state
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  op_t  spi_q[$];
  op_t  host_q[$];
  gnt_t expq[$];
  rd_t  srq[$];
  rd_t  hrq[$];
  op_t  cur [2];
  logic act [2];
  logic fin [2];
  int   pres_pct = 100;
  logic lock_v = 1'b0;
  logic mbusy = 1'b0;
  int   hcnt = 0;

  task automatic check(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, a, e);
    end
  endtask

  // One cycle: drive requesters at the falling edge, then let the model decide.
  task automatic step();
    logic g;
    logic hw;
    logic sw;
    logic port;
    op_t  o;
    gnt_t e;
    rd_t  r;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      g = (p == 0) ? bus.spi_gnt : bus.host_gnt;
      if (act[p] && !fin[p] && g) fin[p] = 1'b1;
      else if (act[p] && fin[p]) begin
        act[p] = 1'b0;
        fin[p] = 1'b0;
      end
      if (!act[p] && ($urandom_range(99) < pres_pct)) begin
        if (p == 0 && spi_q.size() != 0) begin
          cur[0] = spi_q.pop_front();
          act[0] = 1'b1;
        end else if (p == 1 && host_q.size() != 0) begin
          cur[1] = host_q.pop_front();
          act[1] = 1'b1;
        end
      end
    end
    bus.spi_req    = act[0];
    bus.spi_we     = cur[0].we;
    bus.spi_addr   = cur[0].addr;
    bus.spi_wdata  = cur[0].wdata;
    bus.host_req   = act[1];
    bus.host_we    = cur[1].we;
    bus.host_addr  = cur[1].addr;
    bus.host_wdata = cur[1].wdata;
`ifdef DM_ARB_LOCK_EN
    bus.spi_lock   = lock_v;
`endif
    if (mbusy) begin
      mbusy = 1'b0;
    end else begin
      hw = act[1] && !lock_v && (!act[0] || hcnt == SL);
      sw = act[0] && !hw;
      if (act[1] && sw && !lock_v) hcnt = (hcnt < SL) ? hcnt + 1 : SL;
      else hcnt = 0;
      if (hw || sw) begin
        port    = hw;
        o       = cur[port];
        e.port  = port;
        e.we    = o.we;
        e.addr  = o.addr;
        e.wdata = o.we ? o.wdata : '0;
        e.cyc   = cyc + 1;
        expq.push_back(e);
        if (o.we) ref_mem[o.addr] = o.wdata;
        else begin
          r.data = ref_mem[o.addr];
          r.cyc  = cyc + 2;
          if (port) hrq.push_back(r);
          else      srq.push_back(r);
        end
        mbusy = 1'b1;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (!(act[0] || act[1] || spi_q.size() != 0 || host_q.size() != 0 || mbusy ||
            expq.size() != 0 || srq.size() != 0 || hrq.size() != 0))
        break;
      step();
    end
  endtask

  function automatic op_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    op_t o;
    o.we = we;
    o.addr = a;
    o.wdata = d;
    return o;
  endfunction

  function automatic op_t rnd_op();
    logic [AW-1:0] a;
    case ($urandom_range(5))
      0:       a = '0;
      1:       a = '1;
      default: a = AW'($urandom);
    endcase
    return mk(1'($urandom), a, DW'($urandom));
  endfunction

  // Monitor: pops expectations whenever the DUT presents a grant or read data.
  always @(negedge clk) begin
    gnt_t a;
    gnt_t e;
    rd_t  r;
    rd_t  x;
    if (sb_en) begin
      check("gnt_excl", 64'(bus.spi_gnt && bus.host_gnt), 64'd0);
      check("rv_excl", 64'(bus.spi_rvalid && bus.host_rvalid), 64'd0);
      if (bus.spi_gnt || bus.host_gnt) begin
        a.port  = bus.host_gnt;
        a.we    = bus.dm_we;
        a.addr  = bus.dm_addr;
        a.wdata = bus.dm_we ? bus.dm_wdata : '0;
        a.cyc   = cyc;
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_gnt actual=%0h required=none", a);
        end else begin
          e = expq.pop_front();
          check("grant", 64'(a), 64'(e));
        end
      end else begin
        check("idle_we", 64'(bus.dm_we), 64'd0);
      end
      for (int p = 0; p < 2; p++) begin
        if (p == 0 ? bus.spi_rvalid : bus.host_rvalid) begin
          r.data = bus.rdata;
          r.cyc  = cyc;
          if ((p == 0 ? srq.size() : hrq.size()) == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rvalid port=%0d actual=%0h required=none", p, r);
          end else begin
            x = (p == 0) ? srq.pop_front() : hrq.pop_front();
            check(p == 0 ? "spi_read" : "host_read", 64'(r), 64'(x));
          end
        end
      end
    end
  end

  initial begin
    logic got;
    for (int i = 0; i < 2; i++) begin
      cur[i] = '0;
      act[i] = 1'b0;
      fin[i] = 1'b0;
    end
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = seed_val(i);
    bus.spi_req = 1'b0; bus.spi_we = 1'b0; bus.spi_addr = '0; bus.spi_wdata = '0;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
`ifdef DM_ARB_LOCK_EN
    bus.spi_lock = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_spi_gnt", 64'(bus.spi_gnt), 64'd0);
    check("rst_host_gnt", 64'(bus.host_gnt), 64'd0);
    check("rst_spi_rvalid", 64'(bus.spi_rvalid), 64'd0);
    check("rst_host_rvalid", 64'(bus.host_rvalid), 64'd0);
    check("rst_rdata", 64'(bus.rdata), 64'd0);
    check("rst_dm_we", 64'(bus.dm_we), 64'd0);
    mem_init = 1'b0;
    rst_n = 1'b1;

    // Reset landing in the middle of an SPI write grant
    @(negedge clk);
    bus.spi_req = 1'b1; bus.spi_we = 1'b1; bus.spi_addr = 7'h05; bus.spi_wdata = 8'hA5;
    got = 1'b0;
    for (int i = 0; i < 5 && !got; i++) begin
      @(negedge clk);
      if (bus.spi_gnt) got = 1'b1;
    end
    check("pre_rst_gnt", 64'(got), 64'd1);
    check("pre_rst_we", 64'(bus.dm_we), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we", 64'(bus.dm_we), 64'd0);
    check("mid_rst_gnt", 64'(bus.spi_gnt), 64'd0);
    bus.spi_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb_en = 1'b1;

    spi_q.push_back(mk(1'b0, 7'h05, 8'h00));
    spi_q.push_back(mk(1'b1, 7'h12, 8'h3C));
    spi_q.push_back(mk(1'b0, 7'h12, 8'h00));
    drain();
    host_q.push_back(mk(1'b1, 7'h7F, 8'hFF));
    host_q.push_back(mk(1'b0, 7'h7F, 8'h00));
    drain();
    spi_q.push_back(mk(1'b0, 7'h7F, 8'h00));
    drain();
    spi_q.push_back(mk(1'b0, 7'h12, 8'h00));
    host_q.push_back(mk(1'b0, 7'h7F, 8'h00));
    drain();
    for (int i = 0; i < 8; i++) spi_q.push_back(mk(1'b0, AW'(i), 8'h00));
    host_q.push_back(mk(1'b0, 7'h12, 8'h00));
    drain();

`ifdef DM_ARB_LOCK_EN
    lock_v = 1'b1;
    host_q.push_back(mk(1'b0, 7'h7F, 8'h00));
    spi_q.push_back(mk(1'b1, 7'h20, 8'h5A));
    repeat (20) step();
    lock_v = 1'b0;
    drain();
`endif

    pres_pct = 60;
    for (int k = 0; k < 1500; k++) begin
      if (spi_q.size() < 2 && $urandom_range(2) == 0) spi_q.push_back(rnd_op());
      if (host_q.size() < 2 && $urandom_range(2) == 0) host_q.push_back(rnd_op());
`ifdef DM_ARB_LOCK_EN
      if ($urandom_range(15) == 0) lock_v = ~lock_v;
`endif
      step();
    end
    lock_v = 1'b0;
    pres_pct = 100;
    drain();
    repeat (3) step();

    check("left_grants", 64'(expq.size()), 64'd0);
    check("left_spi_reads", 64'(srq.size()), 64'd0);
    check("left_host_reads", 64'(hrq.size()), 64'd0);
    check("left_ops", 64'(spi_q.size() + host_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
